avl_mem_responder: RTL and testbench
====================================

Name: avl_mem_responder

Overview:
- Avalon-MM slave (responder) that terminates the 32-bit mem_* request bus driven by the DMA bridge in the top level.
- Serves single and burst reads/writes against an internal word-addressed block RAM, using waitrequest backpressure and a fixed-latency readdatavalid pipeline.
- Used as a standalone target for the bridge (sector staging buffer, bench stand-in for the system memory port).

Parameters:
- AW, 10, word address width; RAM depth is 2**AW 32-bit words.
- READ_LAT, 2, cycles from read-beat issue to readdatavalid (1..4).
- BCW, 8, burstcount width.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- mem_address  in  32  word address; only bits [AW-1:0] are used.
- mem_read  in  1  read request.
- mem_write  in  1  write request/beat.
- mem_writedata  in  32  write data.
- mem_byteenable  in  4  per-byte write enable.
- mem_burstcount  in  BCW  beats; sampled on the first accepted beat only.
- mem_waitrequest  out  1  command not accepted this cycle.
- mem_readdata  out  32  read data.
- mem_readdatavalid  out  1  mem_readdata valid.
- proto_err  out  1  sticky protocol-violation flag.
- busy  out  1  state != IDLE or read pipeline non-empty.

Behaviour:
- Reset values (asynchronous, reset_n=0):
  - mem_waitrequest=1, mem_readdatavalid=0, mem_readdata=0, proto_err=0, busy=0.
  - State IDLE; pipeline valid bits cleared. RAM contents are not reset.
  - First cycle after reset release: mem_waitrequest=0.
- Command acceptance: a beat is accepted when (mem_read|mem_write) & ~mem_waitrequest.
- Burst length: burstcount 0 is treated as 1. Addresses increment by 1 per beat and wrap modulo 2**AW.
- State machine:
  - IDLE:
    - Accepted read, burstcount N: issue beat 0 this cycle. If N>1, go to RD_BURST with remaining=N-1, addr+1.
    - Accepted write: write beat 0 this cycle. If N>1, go to WR_BURST with remaining=N-1.
  - RD_BURST:
    - mem_waitrequest=1 (inputs ignored).
    - One internal read beat issued per cycle; return to IDLE after the last beat is issued.
  - WR_BURST:
    - mem_waitrequest=0. Each cycle with mem_write=1 is one beat; mem_write=0 is a bubble (no write, no count).
    - mem_read=1 sets proto_err and is ignored.
    - Return to IDLE after the final beat.
- Read timing:
  - A beat issued in cycle t produces mem_readdatavalid=1 with data in cycle t+READ_LAT.
  - Beats return in order; a burst of N beats yields N consecutive valid cycles.
- Writes: byte lanes with byteenable=0 are left unchanged. A write is visible to a read beat issued on the next cycle or later.
- Simultaneous mem_read & mem_write in IDLE: the write is performed, the read is dropped, proto_err is set.
- Back-to-back: a new command may be accepted in the cycle after the last read beat issues, so the read pipeline can overlap. mem_readdatavalid has no backpressure.
- Read pipeline depth is exactly READ_LAT; it never overflows because at most one beat issues per cycle.
- busy stays 1 until the last readdatavalid has been presented.

Optional Feature:
- AVL_RESP_BUSY_INJECT_EN, when defined:
  - A 16-bit LFSR (seed 16'hACE1, reset to seed) forces mem_waitrequest=1 in IDLE and WR_BURST whenever lfsr[1:0]==0.
  - Used to stress initiator stall handling.
- Undefined: no LFSR logic; waitrequest is exactly as specified above.

Decomposition:
- Package avl_resp_pkg: state enum (IDLE, RD_BURST, WR_BURST), LFSR seed/taps constants, default parameter constants.
- Sub-module avl_rd_pipe: READ_LAT-deep valid/data shift pipeline wrapped around the RAM read port.

Test Plan:
- Reset, then single write addr 5 data 32'hDEADBEEF be 4'hF, then read addr 5 -> readdatavalid exactly READ_LAT cycles after read acceptance with data DEADBEEF; waitrequest=0 on the first cycle after reset release.
- Byte-enable: write 0x11223344 to addr 7, then write 0xAABBCCDD be 4'b0101 -> read of addr 7 returns 0x11BB33DD.
- Burst read count 4 at addr 2**AW-2 after writing words 0..3 -> waitrequest high 3 cycles; 4 consecutive valids; data from addrs 2**AW-2, 2**AW-1, 0, 1 (wrap).
- Burst write count 3 with a bubble cycle between beats 1 and 2 -> exactly 3 words written; return to IDLE after beat 3; busy returns to 0.
- mem_read & mem_write together in IDLE -> write performed, no readdatavalid, proto_err=1 and sticky until reset.
- reset_n low in the middle of a 4-beat read burst -> readdatavalid drops to 0 immediately; no further valids after release; state IDLE.

Source files
------------

// File: rtl/avl_resp_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// avl_resp_pkg : state encoding, LFSR constants and default parameters
// Rev 1.0
// -----------------------------------------------------------------------------
package avl_resp_pkg;

  localparam int AW_DEF       = 10;
  localparam int READ_LAT_DEF = 2;
  localparam int BCW_DEF      = 8;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_RD_BURST = 2'd1;
  localparam logic [1:0] S_WR_BURST = 2'd2;

  // Galois right-shift form, x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage
`default_nettype wire

// File: rtl/avl_rd_pipe.sv
`default_nettype none
// -----------------------------------------------------------------------------
// avl_rd_pipe : READ_LAT-deep valid/data pipeline behind the RAM read register
// Rev 1.0
// -----------------------------------------------------------------------------
module avl_rd_pipe #(
  parameter int READ_LAT = 2
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        issue_i,
  input  logic [31:0] rdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        busy_o
);

  logic [READ_LAT-1:0] vld_q;
  logic [31:0]         w_data;

  // rdata_i is the RAM output register, already one stage past the issue
  generate
    if (READ_LAT == 1) begin : g_lat1
      always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) vld_q <= '0;
        else          vld_q <= issue_i;
      end
      assign w_data = rdata_i;
    end else begin : g_latn
      logic [31:0] dat_q [1:READ_LAT-1];

      always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) vld_q <= '0;
        else          vld_q <= {vld_q[READ_LAT-2:0], issue_i};
      end

      always_ff @(posedge clk_sys) begin
        dat_q[1] <= rdata_i;
        for (int i = 2; i < READ_LAT; i++) dat_q[i] <= dat_q[i-1];
      end
      assign w_data = dat_q[READ_LAT-1];
    end
  endgenerate

  assign rvalid_o = vld_q[READ_LAT-1];
  assign rdata_o  = vld_q[READ_LAT-1] ? w_data : 32'h0;
  assign busy_o   = |vld_q;

endmodule
`default_nettype wire

// File: rtl/avl_mem_responder.sv
`default_nettype none
// -----------------------------------------------------------------------------
// avl_mem_responder : Avalon-MM burst slave over a word-addressed block RAM
// Option macro AVL_RESP_BUSY_INJECT_EN: LFSR-driven random waitrequest stalls
// Rev 1.0
// -----------------------------------------------------------------------------
module avl_mem_responder
  import avl_resp_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int READ_LAT = READ_LAT_DEF,
  parameter int BCW      = BCW_DEF
) (
  input  logic           clk_sys,
  input  logic           reset_n,
  input  logic [31:0]    mem_address,
  input  logic           mem_read,
  input  logic           mem_write,
  input  logic [31:0]    mem_writedata,
  input  logic [3:0]     mem_byteenable,
  input  logic [BCW-1:0] mem_burstcount,
  output logic           mem_waitrequest,
  output logic [31:0]    mem_readdata,
  output logic           mem_readdatavalid,
  output logic           proto_err,
  output logic           busy
);

  localparam int DEPTH = 2 ** AW;

  logic [1:0]     state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [BCW-1:0] remain_q, remain_d;
  logic           proto_q, proto_d;

  logic [31:0]    ram [DEPTH];
  logic [31:0]    ram_q;

  logic           w_inject;
  logic           w_accept;
  logic           w_wr_en;
  logic           w_rd_en;
  logic [AW-1:0]  w_wr_addr;
  logic [AW-1:0]  w_rd_addr;
  logic [BCW-1:0] w_count;
  logic           w_pipe_busy;
  logic           w_unused;

  assign w_unused = ^mem_address[31:AW];

`ifdef AVL_RESP_BUSY_INJECT_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_d;
  end

  assign w_inject = (lfsr_q[1:0] == 2'b00) && (state_q != S_RD_BURST);
`else
  assign w_inject = 1'b0;
`endif

  assign w_count         = (mem_burstcount == '0) ? BCW'(1) : mem_burstcount;
  assign mem_waitrequest = ~reset_n | (state_q == S_RD_BURST) | w_inject;
  assign w_accept        = (mem_read | mem_write) & ~mem_waitrequest;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    proto_d   = proto_q;
    w_wr_en   = 1'b0;
    w_rd_en   = 1'b0;
    w_wr_addr = addr_q;
    w_rd_addr = addr_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          w_wr_addr = mem_address[AW-1:0];
          w_rd_addr = mem_address[AW-1:0];
          addr_d    = mem_address[AW-1:0] + 1'b1;
          remain_d  = w_count - 1'b1;
          // a write wins over a simultaneous read; the read is dropped and flagged
          if (mem_write) begin
            w_wr_en = 1'b1;
            proto_d = proto_q | mem_read;
            if (w_count != BCW'(1)) state_d = S_WR_BURST;
          end else begin
            w_rd_en = 1'b1;
            if (w_count != BCW'(1)) state_d = S_RD_BURST;
          end
        end
      end
      S_RD_BURST: begin
        w_rd_en  = 1'b1;
        addr_d   = addr_q + 1'b1;
        remain_d = remain_q - 1'b1;
        if (remain_q == BCW'(1)) state_d = S_IDLE;
      end
      S_WR_BURST: begin
        if (mem_read) proto_d = 1'b1;
        if (mem_write && !mem_waitrequest) begin
          w_wr_en  = 1'b1;
          addr_d   = addr_q + 1'b1;
          remain_d = remain_q - 1'b1;
          if (remain_q == BCW'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      proto_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      proto_q  <= proto_d;
    end
  end

  // RAM and its output register carry no reset so they map onto block RAM
  always_ff @(posedge clk_sys) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_byteenable[b]) ram[w_wr_addr][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end
    end
    if (w_rd_en) ram_q <= ram[w_rd_addr];
  end

  avl_rd_pipe #(
    .READ_LAT (READ_LAT)
  ) u_rd_pipe (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .issue_i  (w_rd_en),
    .rdata_i  (ram_q),
    .rvalid_o (mem_readdatavalid),
    .rdata_o  (mem_readdata),
    .busy_o   (w_pipe_busy)
  );

  assign proto_err = proto_q;
  assign busy      = (state_q != S_IDLE) | w_pipe_busy;

endmodule
`default_nettype wire

// File: tb/tb_avl_mem_responder.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_avl_mem_responder : vector table, directed corner sequences and random
// traffic checked against a transaction-level memory model
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_avl_mem_responder;

  localparam int AW       = 10;
  localparam int READ_LAT = 2;
  localparam int BCW      = 8;
  localparam int DEPTH    = 1 << AW;

  logic           clk_sys = 1'b0;
  logic           reset_n = 1'b0;
  logic [31:0]    mem_address = '0;
  logic           mem_read = 1'b0;
  logic           mem_write = 1'b0;
  logic [31:0]    mem_writedata = '0;
  logic [3:0]     mem_byteenable = '0;
  logic [BCW-1:0] mem_burstcount = '0;
  logic           mem_waitrequest;
  logic [31:0]    mem_readdata;
  logic           mem_readdatavalid;
  logic           proto_err;
  logic           busy;

  always #5 clk_sys = ~clk_sys;

  avl_mem_responder #(.AW(AW), .READ_LAT(READ_LAT), .BCW(BCW)) dut (
    .clk_sys           (clk_sys),
    .reset_n           (reset_n),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_writedata     (mem_writedata),
    .mem_byteenable    (mem_byteenable),
    .mem_burstcount    (mem_burstcount),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdata      (mem_readdata),
    .mem_readdatavalid (mem_readdatavalid),
    .proto_err         (proto_err),
    .busy              (busy)
  );

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    bit          wr;
    int          addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cur   = 0;
  bit          exp_proto = 1'b0;
  logic [31:0] model [DEPTH];
  exp_t        expq[$];
  logic [31:0] rd_log[$];
  vec_t        vecs [9];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cur);
    end
  endtask

  function automatic void mwrite(int addr, logic [31:0] d, logic [3:0] be);
    int a;
    a = addr & (DEPTH - 1);
    for (int b = 0; b < 4; b++) if (be[b]) model[a][b*8 +: 8] = d[b*8 +: 8];
  endfunction

  function automatic logic [31:0] logged(int i);
    if (i < rd_log.size()) return rd_log[i];
    return 32'hxxxxxxxx;
  endfunction

  function automatic bit accepting();
    return (mem_read || mem_write) && !mem_waitrequest;
  endfunction

  // Every cycle: readdatavalid must appear exactly when a queued beat is due
  task automatic tick();
    @(posedge clk_sys);
    cur++;
    @(negedge clk_sys);
    if (expq.size() > 0 && expq[0].cyc == cur) begin
      chk("rdvalid", mem_readdatavalid, 1);
      chk("rddata", mem_readdata, expq[0].data);
      rd_log.push_back(mem_readdata);
      expq.delete(0);
    end else begin
      chk("rdvalid_idle", mem_readdatavalid, 0);
    end
    chk("proto_err", proto_err, exp_proto);
  endtask

  task automatic wait_ready();
    int g = 0;
    while (!accepting() && g < 64) begin
      tick();
      g++;
    end
    chk("accept", accepting(), 1);
  endtask

  task automatic do_write(int addr, logic [31:0] d, logic [3:0] be);
    mem_address = 32'(addr); mem_writedata = d; mem_byteenable = be;
    mem_burstcount = BCW'(1); mem_write = 1'b1;
    wait_ready();
    mwrite(addr, d, be);
    tick();
    mem_write = 1'b0;
  endtask

  task automatic do_read(int addr, int n);
    int nb;
    nb = (n == 0) ? 1 : n;
    mem_address = 32'(addr); mem_burstcount = BCW'(n); mem_read = 1'b1;
    wait_ready();
    for (int i = 0; i < nb; i++)
      expq.push_back('{cur + READ_LAT + i, model[(addr + i) & (DEPTH - 1)]});
    tick();
    mem_read = 1'b0;
  endtask

  task automatic do_wburst(int addr, int n, int bubble_pct);
    int k = 1;
    int g = 0;
    mem_address = 32'(addr); mem_burstcount = BCW'(n); mem_byteenable = 4'hF;
    mem_writedata = $urandom; mem_write = 1'b1;
    wait_ready();
    mwrite(addr, mem_writedata, 4'hF);
    tick();
    while (k < n && g < 300) begin
      mem_write      = ($urandom_range(99) >= bubble_pct);
      mem_writedata  = $urandom;
      mem_byteenable = 4'($urandom_range(15));
      if (accepting()) begin
        mwrite(addr + k, mem_writedata, mem_byteenable);
        k++;
      end
      tick();
      g++;
    end
    mem_write = 1'b0;
    chk("wburst_beats", k, n);
  endtask

  task automatic drain();
    int g = 0;
    while (expq.size() > 0 && g < 100) begin
      tick();
      g++;
    end
    chk("drain", expq.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 5, 32'hDEADBEEF, 4'hF, 32'h0};
    vecs[1] = '{1'b0, 5, 32'h0,        4'h0, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 7, 32'h11223344, 4'hF, 32'h0};
    vecs[3] = '{1'b1, 7, 32'hAABBCCDD, 4'h5, 32'h0};
    vecs[4] = '{1'b0, 7, 32'h0,        4'h0, 32'h11BB33DD};
    vecs[5] = '{1'b1, 9, 32'hCAFEF00D, 4'hF, 32'h0};
    vecs[6] = '{1'b1, 9, 32'h12345678, 4'h8, 32'h0};
    vecs[7] = '{1'b1, 9, 32'hFFFFFFFF, 4'h0, 32'h0};
    vecs[8] = '{1'b0, 9, 32'h0,        4'h0, 32'h12FEF00D};
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    // reset state, then the first cycle after release must accept
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("rst_waitreq", mem_waitrequest, 1);
    chk("rst_rdvalid", mem_readdatavalid, 0);
    chk("rst_rddata", mem_readdata, 0);
    chk("rst_proto", proto_err, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    #1;
    chk("first_waitreq", mem_waitrequest, 0);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].be);
      end else begin
        rd_log.delete();
        do_read(vecs[i].addr, 1);
        drain();
        chk($sformatf("vec%0d_data", i), logged(0), vecs[i].exp);
      end
    end

    // burst read wrapping past the top of the address space
    do_write(DEPTH - 2, 32'hA000_0002, 4'hF);
    do_write(DEPTH - 1, 32'hA000_0001, 4'hF);
    do_write(0,         32'hB000_0000, 4'hF);
    do_write(1,         32'hB000_0001, 4'hF);
    rd_log.delete();
    do_read(DEPTH - 2, 4);
    for (int i = 0; i < 3; i++) begin
      chk("rdb_waitreq_hi", mem_waitrequest, 1);
      tick();
    end
    chk("rdb_waitreq_lo", mem_waitrequest, 0);
    drain();
    chk("rdb_count", rd_log.size(), 4);
    chk("rdb_w0", logged(0), 32'hA000_0002);
    chk("rdb_w1", logged(1), 32'hA000_0001);
    chk("rdb_w2", logged(2), 32'hB000_0000);
    chk("rdb_w3", logged(3), 32'hB000_0001);

    // 3-beat write burst with one bubble between beats 1 and 2
    do_write(99,  32'h6666_6666, 4'hF);
    do_write(103, 32'h5555_5555, 4'hF);
    mem_address = 32'd100; mem_burstcount = BCW'(3); mem_byteenable = 4'hF;
    mem_writedata = 32'hC000_0000; mem_write = 1'b1;
    wait_ready();
    mwrite(100, mem_writedata, 4'hF);
    tick();
    chk("wrb_busy_mid", busy, 1);
    mem_writedata = 32'hC000_0001;
    wait_ready();
    mwrite(101, mem_writedata, 4'hF);
    tick();
    mem_write = 1'b0;
    mem_writedata = 32'hDEAD_0000;
    tick();
    chk("wrb_busy_bubble", busy, 1);
    mem_writedata = 32'hC000_0002; mem_write = 1'b1;
    wait_ready();
    mwrite(102, mem_writedata, 4'hF);
    tick();
    mem_write = 1'b0;
    chk("wrb_busy_done", busy, 0);
    rd_log.delete();
    do_read(99, 5);
    drain();
    chk("wrb_a99",  logged(0), 32'h6666_6666);
    chk("wrb_a100", logged(1), 32'hC000_0000);
    chk("wrb_a101", logged(2), 32'hC000_0001);
    chk("wrb_a102", logged(3), 32'hC000_0002);
    chk("wrb_a103", logged(4), 32'h5555_5555);
    tick();
    chk("wrb_busy_idle", busy, 0);

    // simultaneous read and write in IDLE: write wins, no read data
    mem_address = 32'd20; mem_writedata = 32'h0BAD_F00D; mem_byteenable = 4'hF;
    mem_burstcount = BCW'(1); mem_read = 1'b1; mem_write = 1'b1;
    wait_ready();
    mwrite(20, mem_writedata, 4'hF);
    exp_proto = 1'b1;
    tick();
    mem_read = 1'b0; mem_write = 1'b0;
    repeat (READ_LAT + 2) tick();
    rd_log.delete();
    do_read(20, 1);
    drain();
    chk("both_data", logged(0), 32'h0BAD_F00D);

    // reset in the middle of a 4-beat read burst
    do_read(0, 4);
    tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_rdvalid", mem_readdatavalid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_proto", proto_err, 0);
    expq.delete();
    exp_proto = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    #1;
    chk("postrst_waitreq", mem_waitrequest, 0);
    repeat (6) tick();
    chk("postrst_busy", busy, 0);

    // random back-to-back traffic inside two pre-filled address windows
    do_wburst(0, 32, 0);
    do_wburst(DEPTH - 8, 8, 0);
    for (int t = 0; t < 150; t++) begin
      int op, addr, n;
      op   = $urandom_range(2);
      addr = ($urandom_range(1) == 1) ? $urandom_range(25) : DEPTH - 8 + $urandom_range(7);
      case (op)
        0:       do_write(addr, $urandom, 4'($urandom_range(15)));
        1:       do_read(addr, $urandom_range(6));
        default: do_wburst(addr, $urandom_range(5, 1), 30);
      endcase
      if ($urandom_range(3) == 0) tick();
    end
    drain();
    tick();
    chk("final_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
